// File: rtl/reg_wb_pkg.sv
// Shared definitions for the register write-back unit: source encodings,
// FSM state type and the register-address range helper.
package reg_wb_pkg;

    localparam logic [1:0] WB_SRC_ALU  = 2'b00;
    localparam logic [1:0] WB_SRC_LIT  = 2'b01;
    localparam logic [1:0] WB_SRC_MEM  = 2'b10;
    localparam logic [1:0] WB_SRC_NONE = 2'b11;

    typedef enum logic {
        WB_IDLE     = 1'b0,
        WB_WAIT_MEM = 1'b1
    } wb_state_e;

    // Callers zero-extend to 32 bits so the check stays meaningful for any REG_COUNT.
    function automatic logic adr_in_range(input logic [31:0] adr, input logic [31:0] count);
        return (adr < count);
    endfunction

endpackage

// File: rtl/reg_wb_regfile.sv
// Register storage with one write port and two combinational read ports.
// Reads see a write committing at the coming edge; out-of-range reads return 0.
module reg_wb_regfile
    import reg_wb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int REG_COUNT  = 8,
    parameter int ADR_WIDTH  = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADR_WIDTH-1:0]  wr_adr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADR_WIDTH-1:0]  rd_adr_a,
    input  logic [ADR_WIDTH-1:0]  rd_adr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b
);

    logic [DATA_WIDTH-1:0] regs_r [REG_COUNT];
    logic                  wr_ok_s;
    logic                  rd_ok_a_s;
    logic                  rd_ok_b_s;

    assign wr_ok_s   = wr_en && adr_in_range(32'(wr_adr), 32'(REG_COUNT));
    assign rd_ok_a_s = adr_in_range(32'(rd_adr_a), 32'(REG_COUNT));
    assign rd_ok_b_s = adr_in_range(32'(rd_adr_b), 32'(REG_COUNT));

    // Storage array: cleared on reset, written only for in-range addresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wr_ok_s) begin
            regs_r[wr_adr] <= wr_data;
        end
    end

    // Read port A with same-cycle write bypass.
    always_comb begin
        rd_data_a = '0;
        if (rd_ok_a_s) begin
            if (wr_ok_s && (wr_adr == rd_adr_a)) begin
                rd_data_a = wr_data;
            end else begin
                rd_data_a = regs_r[rd_adr_a];
            end
        end else begin
            rd_data_a = '0;
        end
    end

    // Read port B with same-cycle write bypass.
    always_comb begin
        rd_data_b = '0;
        if (rd_ok_b_s) begin
            if (wr_ok_s && (wr_adr == rd_adr_b)) begin
                rd_data_b = wr_data;
            end else begin
                rd_data_b = regs_r[rd_adr_b];
            end
        end else begin
            rd_data_b = '0;
        end
    end

endmodule

// File: rtl/reg_wb_unit.sv
// Register write-back unit: selects ALU / literal / memory-load data, sequences
// loads through a bounded wait, and commits into the register file.
module reg_wb_unit
    import reg_wb_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int REG_COUNT   = 8,
    parameter int ADR_WIDTH   = $clog2(REG_COUNT),
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [1:0]            wr_sel,
    input  logic [ADR_WIDTH-1:0]  wr_adr,
    input  logic [DATA_WIDTH-1:0] result,
    input  logic [DATA_WIDTH-1:0] literal_adr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_valid,
    input  logic [ADR_WIDTH-1:0]  rd_adr_a,
    input  logic [ADR_WIDTH-1:0]  rd_adr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic [DATA_WIDTH-1:0] reg_val,
    output logic                  wr_done,
    output logic                  busy,
    output logic                  mem_err
);

    localparam int               CNT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    wb_state_e             state_r;
    wb_state_e             state_nxt_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_nxt_s;
    logic [ADR_WIDTH-1:0]  pend_adr_r;
    logic [ADR_WIDTH-1:0]  pend_adr_nxt_s;
    logic [DATA_WIDTH-1:0] reg_val_r;
    logic                  wr_done_r;
    logic                  mem_err_r;
    logic                  mem_err_nxt_s;
    logic                  req_ok_s;
    logic                  commit_s;
    logic [ADR_WIDTH-1:0]  wb_adr_s;
    logic [DATA_WIDTH-1:0] wb_data_s;

    // Out-of-range destinations are rejected at request time, loads included.
    assign req_ok_s = wr_en && adr_in_range(32'(wr_adr), 32'(REG_COUNT));

    // Next-state, source select and timeout logic.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        pend_adr_nxt_s = pend_adr_r;
        mem_err_nxt_s  = mem_err_r;
        commit_s       = 1'b0;
        wb_adr_s       = wr_adr;
        wb_data_s      = result;
        case (state_r)
            WB_IDLE: begin
                if (req_ok_s) begin
                    case (wr_sel)
                        WB_SRC_ALU: begin
                            commit_s  = 1'b1;
                            wb_data_s = result;
                        end
                        WB_SRC_LIT: begin
                            commit_s  = 1'b1;
                            wb_data_s = literal_adr;
                        end
                        WB_SRC_MEM: begin
                            state_nxt_s    = WB_WAIT_MEM;
                            pend_adr_nxt_s = wr_adr;
                            cnt_nxt_s      = '0;
                        end
                        default: begin
                            commit_s = 1'b0;
                        end
                    endcase
                end else begin
                    commit_s = 1'b0;
                end
            end
            WB_WAIT_MEM: begin
                // Load data wins over an expiring timeout in the same cycle.
                if (mem_valid) begin
                    commit_s    = 1'b1;
                    wb_adr_s    = pend_adr_r;
                    wb_data_s   = mem_data;
                    state_nxt_s = WB_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s   = WB_IDLE;
                    mem_err_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = WB_IDLE;
            end
        endcase
    end

    // FSM state, timeout counter and pending load address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= WB_IDLE;
            cnt_r      <= '0;
            pend_adr_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            pend_adr_r <= pend_adr_nxt_s;
        end
    end

    // Registered commit status outputs; mem_err is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_val_r <= '0;
            wr_done_r <= 1'b0;
            mem_err_r <= 1'b0;
        end else begin
            reg_val_r <= commit_s ? wb_data_s : reg_val_r;
            wr_done_r <= commit_s;
            mem_err_r <= mem_err_nxt_s;
        end
    end

    assign reg_val = reg_val_r;
    assign wr_done = wr_done_r;
    assign mem_err = mem_err_r;
    assign busy    = (state_r == WB_WAIT_MEM);

    reg_wb_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT),
        .ADR_WIDTH  (ADR_WIDTH)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (commit_s),
        .wr_adr    (wb_adr_s),
        .wr_data   (wb_data_s),
        .rd_adr_a  (rd_adr_a),
        .rd_adr_b  (rd_adr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b)
    );

endmodule

// File: tb/tb_reg_wb_unit.sv
// Bench for reg_wb_unit (REG_COUNT=6, MEM_TIMEOUT=4): directed scenarios then
// random traffic, all compared against a behavioural register/load model.
module tb_reg_wb_unit;

    localparam int DW = 8;
    localparam int RC = 6;
    localparam int AW = 3;
    localparam int TO = 4;

    logic          clk         = 1'b0;
    logic          rst_n       = 1'b1;
    logic          wr_en       = 1'b0;
    logic [1:0]    wr_sel      = 2'b11;
    logic [AW-1:0] wr_adr      = '0;
    logic [DW-1:0] result      = '0;
    logic [DW-1:0] literal_adr = '0;
    logic [DW-1:0] mem_data    = '0;
    logic          mem_valid   = 1'b0;
    logic [AW-1:0] rd_adr_a    = '0;
    logic [AW-1:0] rd_adr_b    = '0;
    logic [DW-1:0] rd_data_a;
    logic [DW-1:0] rd_data_b;
    logic [DW-1:0] reg_val;
    logic          wr_done;
    logic          busy;
    logic          mem_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model: register contents, outstanding load and its age.
    logic [DW-1:0] m_regs [RC];
    bit            m_pend;
    int            m_padr;
    int            m_age;
    logic [DW-1:0] m_val;
    bit            m_done;
    bit            m_err;
    bit            c_commit;
    int            c_adr;
    logic [DW-1:0] c_val;

    always #5 clk = ~clk;

    reg_wb_unit #(
        .DATA_WIDTH  (DW),
        .REG_COUNT   (RC),
        .ADR_WIDTH   (AW),
        .MEM_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_adr      (wr_adr),
        .result      (result),
        .literal_adr (literal_adr),
        .mem_data    (mem_data),
        .mem_valid   (mem_valid),
        .rd_adr_a    (rd_adr_a),
        .rd_adr_b    (rd_adr_b),
        .rd_data_a   (rd_data_a),
        .rd_data_b   (rd_data_b),
        .reg_val     (reg_val),
        .wr_done     (wr_done),
        .busy        (busy),
        .mem_err     (mem_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < RC; i++) m_regs[i] = '0;
        m_pend = 1'b0; m_padr = 0; m_age = 0;
        m_val = '0; m_done = 1'b0; m_err = 1'b0;
    endtask

    task automatic set_idle();
        wr_en = 1'b0; wr_sel = 2'b11; mem_valid = 1'b0;
    endtask

    // What, if anything, gets written at the coming edge.
    task automatic predict();
        c_commit = 1'b0; c_adr = 0; c_val = '0;
        if (!m_pend) begin
            if (wr_en && int'(wr_adr) < RC && wr_sel == 2'b00) begin
                c_commit = 1'b1; c_adr = int'(wr_adr); c_val = result;
            end else if (wr_en && int'(wr_adr) < RC && wr_sel == 2'b01) begin
                c_commit = 1'b1; c_adr = int'(wr_adr); c_val = literal_adr;
            end
        end else if (mem_valid) begin
            c_commit = 1'b1; c_adr = m_padr; c_val = mem_data;
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (int'(a) >= RC) return '0;
        if (c_commit && c_adr == int'(a)) return c_val;
        return m_regs[a];
    endfunction

    task automatic model_edge();
        m_done = c_commit;
        if (c_commit) begin
            m_regs[c_adr] = c_val;
            m_val = c_val;
        end
        if (!m_pend) begin
            if (wr_en && wr_sel == 2'b10 && int'(wr_adr) < RC) begin
                m_pend = 1'b1; m_padr = int'(wr_adr); m_age = 0;
            end
        end else if (mem_valid) begin
            m_pend = 1'b0;
        end else begin
            m_age++;
            if (m_age == TO) begin
                m_pend = 1'b0;
                m_err  = 1'b1;
            end
        end
    endtask

    // One clock: check combinational outputs, clock, check registered outputs.
    task automatic cycle();
        #1;
        predict();
        chk("rd_a", 32'(rd_data_a), 32'(exp_rd(rd_adr_a)));
        chk("rd_b", 32'(rd_data_b), 32'(exp_rd(rd_adr_b)));
        chk("busy", 32'(busy), 32'(m_pend));
        @(posedge clk);
        #1;
        model_edge();
        chk("reg_val", 32'(reg_val), 32'(m_val));
        chk("wr_done", 32'(wr_done), 32'(m_done));
        chk("mem_err", 32'(mem_err), 32'(m_err));
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic apply_reset();
        set_idle();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(mem_err), 32'd0);
        chk("rst_val", 32'(reg_val), 32'd0);
        chk("rst_done", 32'(wr_done), 32'd0);
        for (int i = 0; i < RC; i++) begin
            rd_adr_a = AW'(i);
            rd_adr_b = AW'(RC - 1 - i);
            #1;
            chk("rst_rd_a", 32'(rd_data_a), 32'd0);
            chk("rst_rd_b", 32'(rd_data_b), 32'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [1:0] sel, input int adr, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_adr = AW'(adr);
        result = d; literal_adr = ~d;
    endtask

    initial begin
        int busy_cnt;
        model_reset();
        @(posedge clk);
        #1;
        apply_reset();

        // ALU write with bypass
        rd_adr_a = 3'd3; rd_adr_b = 3'd0;
        req(2'b00, 3, 8'h44);
        #1 chk("alu_bypass", 32'(rd_data_a), 32'h44);
        cycle();
        chk("alu_val", 32'(reg_val), 32'h44);
        chk("alu_done", 32'(wr_done), 32'd1);
        set_idle();
        cycle();
        chk("alu_done_clr", 32'(wr_done), 32'd0);
        chk("alu_hold", 32'(rd_data_a), 32'h44);

        // Literal write
        wr_en = 1'b1; wr_sel = 2'b01; wr_adr = 3'd5; literal_adr = 8'hF3; result = 8'h00;
        cycle();
        chk("lit_val", 32'(reg_val), 32'hF3);
        set_idle();
        rd_adr_a = 3'd5; rd_adr_b = 3'd3;
        cycle();
        chk("lit_reg5", 32'(rd_data_a), 32'hF3);
        chk("lit_reg3", 32'(rd_data_b), 32'h44);

        // Memory load after three idle cycles; ALU request while busy is lost
        busy_cnt = 0;
        req(2'b10, 2, 8'h00);
        cycle();
        busy_cnt += int'(busy);
        rd_adr_a = 3'd4; rd_adr_b = 3'd2;
        for (int i = 0; i < 3; i++) begin
            req(2'b00, 4, 8'h77);
            cycle();
            busy_cnt += int'(busy);
        end
        set_idle();
        mem_valid = 1'b1; mem_data = 8'hA5;
        #1 chk("load_bypass", 32'(rd_data_b), 32'hA5);
        cycle();
        chk("load_busy_cycles", 32'(busy_cnt), 32'd4);
        chk("load_val", 32'(reg_val), 32'hA5);
        chk("load_done", 32'(wr_done), 32'd1);
        chk("load_busy_clr", 32'(busy), 32'd0);
        chk("load_noerr", 32'(mem_err), 32'd0);
        chk("busy_req_lost", 32'(rd_data_a), 32'h00);
        set_idle();

        // Timeout: no mem_valid within the window
        busy_cnt = 0;
        rd_adr_a = 3'd4;
        req(2'b10, 4, 8'h00);
        cycle();
        busy_cnt += int'(busy);
        set_idle();
        for (int i = 0; i < TO; i++) begin
            cycle();
            busy_cnt += int'(busy);
        end
        chk("to_busy_cycles", 32'(busy_cnt), 32'd4);
        chk("to_err", 32'(mem_err), 32'd1);
        chk("to_nodone", 32'(wr_done), 32'd0);
        mem_valid = 1'b1; mem_data = 8'h5A;
        cycle();
        chk("to_late_valid", 32'(wr_done), 32'd0);
        chk("to_reg_unchanged", 32'(rd_data_a), 32'h00);
        set_idle();

        // Reset in the middle of a load, then a clean load
        req(2'b10, 1, 8'h00);
        cycle();
        set_idle();
        cycle();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        apply_reset();
        rd_adr_a = 3'd2;
        req(2'b10, 2, 8'h00);
        cycle();
        set_idle();
        mem_valid = 1'b1; mem_data = 8'h3C;
        cycle();
        chk("post_rst_load", 32'(reg_val), 32'h3C);
        chk("post_rst_reg2", 32'(rd_data_a), 32'h3C);
        set_idle();

        // Boundaries: no-source select, out-of-range write/read, load with early valid
        req(2'b11, 1, 8'h99);
        cycle();
        chk("sel11_nodone", 32'(wr_done), 32'd0);
        req(2'b00, 7, 8'h11);
        rd_adr_a = 3'd7;
        cycle();
        chk("oor_nodone", 32'(wr_done), 32'd0);
        chk("oor_read", 32'(rd_data_a), 32'd0);
        req(2'b10, 6, 8'h00);
        cycle();
        chk("oor_load_nobusy", 32'(busy), 32'd0);
        req(2'b10, 3, 8'h00);
        mem_valid = 1'b1; mem_data = 8'hEE;
        cycle();
        chk("early_valid_busy", 32'(busy), 32'd1);
        chk("early_valid_nodone", 32'(wr_done), 32'd0);
        set_idle();
        mem_valid = 1'b1; mem_data = 8'h12;
        cycle();
        chk("early_valid_done", 32'(reg_val), 32'h12);
        set_idle();

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            if (n == 300) apply_reset();
            wr_en       = 1'($urandom_range(0, 1));
            wr_sel      = 2'($urandom_range(0, 3));
            wr_adr      = AW'($urandom_range(0, 7));
            result      = DW'($urandom);
            literal_adr = DW'($urandom);
            mem_data    = DW'($urandom);
            mem_valid   = ($urandom_range(0, 9) < 3);
            rd_adr_a    = AW'($urandom_range(0, 7));
            rd_adr_b    = AW'($urandom_range(0, 7));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
